// File: rtl/perip_bus_master.sv
// Peripheral bus initiator: takes one LSU load/store at a time, drives the
// word-addressed peripheral register bus, and turns partial stores into
// read-modify-write sequences because peripherals only take full words.
module perip_bus_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req_valid_i,
   output logic              core_req_ready_o,
   input  logic              core_req_we_i,
   input  logic [ADDR_W-1:0] core_req_addr_i,
   input  logic [DATA_W-1:0] core_req_wdata_i,
   input  logic [DATA_W/8-1:0] core_req_be_i,
   output logic              core_rsp_valid_o,
   output logic [DATA_W-1:0] core_rsp_rdata_o,
   input  logic              core_rsp_ready_i,
   output logic [ADDR_W-1:0] perip_r_addr_o,
   output logic [ADDR_W-1:0] perip_w_addr_o,
   output logic [DATA_W-1:0] perip_data_o,
   output logic              perip_r_enable_o,
   output logic              perip_w_enable_o,
   input  logic [DATA_W-1:0] perip_data_i
);

   localparam int BE_W = DATA_W / 8;

   // RMW_WAIT is the read-latency wait of a partial store; it behaves like
   // RD_WAIT but ends in a write instead of a response.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      RMW_WAIT = 3'd4,
      RESP     = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                rmw_q, rmw_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
   logic [BE_W-1:0]     req_be_q, req_be_d;
   logic                ready_q, ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   r_addr_q, r_addr_d;
   logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
   logic [DATA_W-1:0]   data_o_q, data_o_d;
   logic                r_en_q, r_en_d;
   logic                w_en_q, w_en_d;

   logic                handshake;
   logic                be_full;
   logic                be_none;
   logic                last_beat;
   logic [ADDR_W-1:0]   addr_aligned;
   logic [DATA_W-1:0]   merged;
   logic                unused_addr_lsbs;

   assign handshake        = core_req_valid_i & ready_q & (state_q == IDLE);
   assign be_full          = &core_req_be_i;
   assign be_none          = ~|core_req_be_i;
   assign last_beat        = (cnt_q == 3'd1);
   assign addr_aligned     = {core_req_addr_i[ADDR_W-1:2], 2'b00};
   assign unused_addr_lsbs = ^core_req_addr_i[1:0];

   // Byte-wise merge of the latched store data over the word just read back.
   generate
      for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
         assign merged[gi*8 +: 8] = req_be_q[gi] ? req_wdata_q[gi*8 +: 8]
                                                 : perip_data_i[gi*8 +: 8];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (handshake) begin
               if (!core_req_we_i) state_d = RD_ISSUE;
               else if (be_full)   state_d = WR_ISSUE;
               else if (be_none)   state_d = RESP;
               else                state_d = RD_ISSUE;
            end
         end
         RD_ISSUE: state_d = rmw_q ? RMW_WAIT : RD_WAIT;
         RD_WAIT:  if (last_beat) state_d = RESP;
         RMW_WAIT: if (last_beat) state_d = WR_ISSUE;
         WR_ISSUE: state_d = RESP;
         RESP:     if (rsp_valid_q && core_rsp_ready_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output and datapath next values; every port is driven from a flop, so
   // strobes and handshakes are decoded from the upcoming state.
   always_comb begin
      cnt_d       = cnt_q;
      rmw_d       = rmw_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_be_d    = req_be_q;
      rdata_d     = rdata_q;
      r_addr_d    = r_addr_q;
      w_addr_d    = w_addr_q;
      data_o_d    = data_o_q;
      ready_d     = (state_d == IDLE);
      r_en_d      = (state_d == RD_ISSUE);
      w_en_d      = (state_d == WR_ISSUE);
      // An empty store jumps straight to RESP but still answers one cycle
      // later, so the response is suppressed on the IDLE->RESP entry.
      rsp_valid_d = (state_d == RESP) && (state_q != IDLE);

      if (handshake) begin
         req_addr_d  = addr_aligned;
         req_wdata_d = core_req_wdata_i;
         req_be_d    = core_req_be_i;
         rmw_d       = core_req_we_i & ~be_full & ~be_none;
         rdata_d     = '0;
         if (state_d == RD_ISSUE) r_addr_d = addr_aligned;
         if (state_d == WR_ISSUE) begin
            w_addr_d = addr_aligned;
            data_o_d = core_req_wdata_i;
         end
      end

      case (state_q)
         RD_ISSUE: cnt_d = 3'(RD_LAT);
         RD_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (last_beat) rdata_d = perip_data_i;
         end
         RMW_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (last_beat) begin
               w_addr_d = req_addr_q;
               data_o_d = merged;
            end
         end
         RESP: rmw_d = 1'b0;
         default: ;
      endcase
   end

   // Datapath and output registers; reset also clears the latched request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         rmw_q       <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_be_q    <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         r_addr_q    <= '0;
         w_addr_q    <= '0;
         data_o_q    <= '0;
         r_en_q      <= 1'b0;
         w_en_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         rmw_q       <= rmw_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_be_q    <= req_be_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         r_addr_q    <= r_addr_d;
         w_addr_q    <= w_addr_d;
         data_o_q    <= data_o_d;
         r_en_q      <= r_en_d;
         w_en_q      <= w_en_d;
      end
   end

   assign core_req_ready_o = ready_q;
   assign core_rsp_valid_o = rsp_valid_q;
   assign core_rsp_rdata_o = rdata_q;
   assign perip_r_addr_o   = r_addr_q;
   assign perip_w_addr_o   = w_addr_q;
   assign perip_data_o     = data_o_q;
   assign perip_r_enable_o = r_en_q;
   assign perip_w_enable_o = w_en_q;

endmodule

// File: tb/tb_perip_bus_master.sv
// Directed bench for perip_bus_master: one instance with RD_LAT=1 for the
// main sequences and one with RD_LAT=3 for the long-latency load.
module tb_perip_bus_master;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A (RD_LAT=1)
   logic        a_valid, a_ready, a_we, a_rsp_valid, a_rsp_ready, a_ren, a_wen;
   logic [31:0] a_addr, a_wdata, a_rdata, a_raddr, a_waddr, a_pdo, a_pdi, a_rd_val;
   logic [3:0]  a_be;
   logic        a_pipe;

   // Instance B (RD_LAT=3)
   logic        b_valid, b_ready, b_rsp_valid, b_ren, b_wen;
   logic [31:0] b_addr, b_rdata, b_raddr, b_waddr, b_pdo, b_pdi, b_rd_val;
   logic [2:0]  b_pipe;

   perip_bus_master #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .core_req_valid_i(a_valid), .core_req_ready_o(a_ready),
      .core_req_we_i(a_we), .core_req_addr_i(a_addr),
      .core_req_wdata_i(a_wdata), .core_req_be_i(a_be),
      .core_rsp_valid_o(a_rsp_valid), .core_rsp_rdata_o(a_rdata),
      .core_rsp_ready_i(a_rsp_ready),
      .perip_r_addr_o(a_raddr), .perip_w_addr_o(a_waddr),
      .perip_data_o(a_pdo), .perip_r_enable_o(a_ren),
      .perip_w_enable_o(a_wen), .perip_data_i(a_pdi)
   );

   perip_bus_master #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .core_req_valid_i(b_valid), .core_req_ready_o(b_ready),
      .core_req_we_i(1'b0), .core_req_addr_i(b_addr),
      .core_req_wdata_i(32'h0), .core_req_be_i(4'h0),
      .core_rsp_valid_o(b_rsp_valid), .core_rsp_rdata_o(b_rdata),
      .core_rsp_ready_i(1'b1),
      .perip_r_addr_o(b_raddr), .perip_w_addr_o(b_waddr),
      .perip_data_o(b_pdo), .perip_r_enable_o(b_ren),
      .perip_w_enable_o(b_wen), .perip_data_i(b_pdi)
   );

   // Peripheral models: read data is only meaningful exactly RD_LAT cycles
   // after the read strobe; any other cycle returns a poison word.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_pipe <= 1'b0;
         b_pipe <= 3'b000;
      end else begin
         a_pipe <= a_ren;
         b_pipe <= {b_pipe[1:0], b_ren};
      end
   end
   assign a_pdi = a_pipe    ? a_rd_val : 32'hBAD0_BAD0;
   assign b_pdi = b_pipe[2] ? b_rd_val : 32'hBAD1_BAD1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a_idle_bus(input string tag);
      chk({tag, "_ren"}, 32'(a_ren), 32'd0);
      chk({tag, "_wen"}, 32'(a_wen), 32'd0);
   endtask

   initial begin
      a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
      a_rsp_ready = 1; a_rd_val = 0;
      b_valid = 0; b_addr = 0; b_rd_val = 0;

      // Reset state
      step(); step();
      chk("rst_ready",  32'(a_ready), 32'd0);
      chk("rst_rspv",   32'(a_rsp_valid), 32'd0);
      chk("rst_raddr",  a_raddr, 32'd0);
      chk("rst_pdo",    a_pdo, 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready_a", 32'(a_ready), 32'd1);
      chk("post_rst_ready_b", 32'(b_ready), 32'd1);
      $display("txn reset release");

      // Load 0x1000_0004, RD_LAT=1
      a_addr = 32'h1000_0004; a_we = 0; a_valid = 1; a_rd_val = 32'hDEAD_BEEF;
      step(); a_valid = 0;
      chk("ld_ready_drop", 32'(a_ready), 32'd0);
      chk("ld_ren",        32'(a_ren), 32'd1);
      chk("ld_raddr",      a_raddr, 32'h1000_0004);
      chk("ld_wen",        32'(a_wen), 32'd0);
      step();
      chk("ld_ren_once",   32'(a_ren), 32'd0);
      chk("ld_rspv_early", 32'(a_rsp_valid), 32'd0);
      step();
      chk("ld_rspv",       32'(a_rsp_valid), 32'd1);
      chk("ld_rdata",      a_rdata, 32'hDEAD_BEEF);
      step();
      chk("ld_rspv_done",  32'(a_rsp_valid), 32'd0);
      chk("ld_ready_back", 32'(a_ready), 32'd1);
      chk("ld_raddr_hold", a_raddr, 32'h1000_0004);
      $display("txn load addr=10000004 rdata=%h", 32'hDEAD_BEEF);

      // Full-word store to unaligned address
      a_addr = 32'h1000_0007; a_we = 1; a_be = 4'hF; a_wdata = 32'h1234_5678; a_valid = 1;
      step(); a_valid = 0; a_wdata = 32'hFFFF_FFFF;
      chk("st_wen",   32'(a_wen), 32'd1);
      chk("st_ren",   32'(a_ren), 32'd0);
      chk("st_waddr", a_waddr, 32'h1000_0004);
      chk("st_pdo",   a_pdo, 32'h1234_5678);
      step();
      chk("st_wen_once", 32'(a_wen), 32'd0);
      chk("st_rspv",  32'(a_rsp_valid), 32'd1);
      chk("st_rdata", a_rdata, 32'd0);
      chk("st_pdo_hold", a_pdo, 32'h1234_5678);
      step();
      chk("st_ready_back", 32'(a_ready), 32'd1);
      $display("txn store addr=10000007 data=12345678");

      // Read-modify-write, be=0010
      a_addr = 32'h1000_0008; a_we = 1; a_be = 4'b0010; a_wdata = 32'h0000_AB00;
      a_rd_val = 32'h1122_3344; a_valid = 1;
      step(); a_valid = 0; a_be = 4'hF; a_wdata = 32'h0;
      chk("rmw_ren",   32'(a_ren), 32'd1);
      chk("rmw_wen0",  32'(a_wen), 32'd0);
      chk("rmw_raddr", a_raddr, 32'h1000_0008);
      step();
      chk_a_idle_bus("rmw_wait");
      step();
      chk("rmw_wen",   32'(a_wen), 32'd1);
      chk("rmw_ren1",  32'(a_ren), 32'd0);
      chk("rmw_waddr", a_waddr, 32'h1000_0008);
      chk("rmw_pdo",   a_pdo, 32'h1122_AB44);
      chk("rmw_rspv_early", 32'(a_rsp_valid), 32'd0);
      step();
      chk("rmw_rspv",  32'(a_rsp_valid), 32'd1);
      chk("rmw_rdata", a_rdata, 32'd0);
      chk("rmw_wen_once", 32'(a_wen), 32'd0);
      step();
      $display("txn rmw addr=10000008 merged=%h", 32'h1122_AB44);

      // Response backpressure with a competing request held valid
      a_addr = 32'h0000_0020; a_we = 0; a_rd_val = 32'hCAFE_F00D; a_valid = 1;
      a_rsp_ready = 0;
      step();
      a_addr = 32'h0000_0030; a_we = 1; a_be = 4'hF; a_wdata = 32'h55AA_55AA;
      step(); step();
      chk("bp_rspv_first", 32'(a_rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_rspv_hold",  32'(a_rsp_valid), 32'd1);
         chk("bp_rdata_hold", a_rdata, 32'hCAFE_F00D);
         chk("bp_ready_low",  32'(a_ready), 32'd0);
         chk("bp_no_wen",     32'(a_wen), 32'd0);
      end
      a_rsp_ready = 1;
      step();
      chk("bp_rspv_drop", 32'(a_rsp_valid), 32'd0);
      chk("bp_ready_up",  32'(a_ready), 32'd1);
      chk("bp_no_wen2",   32'(a_wen), 32'd0);
      step(); a_valid = 0;
      chk("bp_next_wen",   32'(a_wen), 32'd1);
      chk("bp_next_waddr", a_waddr, 32'h0000_0030);
      step();
      chk("bp_next_rspv",  32'(a_rsp_valid), 32'd1);
      step();
      $display("txn backpressure load rdata=%h then store addr=00000030", 32'hCAFE_F00D);

      // Store with no byte enables: no bus activity, response after 2 cycles
      a_addr = 32'h0000_0040; a_we = 1; a_be = 4'h0; a_wdata = 32'h7777_7777; a_valid = 1;
      step(); a_valid = 0;
      chk_a_idle_bus("be0_c1");
      chk("be0_rspv_early", 32'(a_rsp_valid), 32'd0);
      step();
      chk_a_idle_bus("be0_c2");
      chk("be0_rspv",  32'(a_rsp_valid), 32'd1);
      chk("be0_rdata", a_rdata, 32'd0);
      step();
      chk("be0_ready", 32'(a_ready), 32'd1);
      $display("txn store be=0 addr=00000040");

      // RD_LAT=3 load: response at handshake+5
      b_addr = 32'h0000_0052; b_rd_val = 32'h0BAD_CAFE; b_valid = 1;
      step(); b_valid = 0;
      chk("l3_ren",   32'(b_ren), 32'd1);
      chk("l3_raddr", b_raddr, 32'h0000_0050);
      step(); step(); step();
      chk("l3_rspv_early", 32'(b_rsp_valid), 32'd0);
      step();
      chk("l3_rspv",  32'(b_rsp_valid), 32'd1);
      chk("l3_rdata", b_rdata, 32'h0BAD_CAFE);
      $display("txn load rd_lat=3 rdata=%h", 32'h0BAD_CAFE);

      // Reset during RD_WAIT aborts the load
      step();
      a_addr = 32'h0000_0060; a_we = 0; a_rd_val = 32'h9999_9999; a_valid = 1;
      step(); a_valid = 0;
      chk("abort_ren", 32'(a_ren), 32'd1);
      step();
      rst_n = 1'b0;
      #1;
      chk("abort_ready0", 32'(a_ready), 32'd0);
      chk("abort_raddr0", a_raddr, 32'd0);
      step(); step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_a_idle_bus("abort_after");
         chk("abort_rspv",  32'(a_rsp_valid), 32'd0);
         chk("abort_ready", 32'(a_ready), 32'd1);
         chk("abort_waddr", a_waddr, 32'd0);
         chk("abort_pdo",   a_pdo, 32'd0);
      end
      $display("txn reset mid-read abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
